// File: rtl/wb_dma_copy.sv
// Word-serial Wishbone (pipelined) copy master: one read then one write per word.
// Optional ack-wait watchdog enabled by defining WB_DMA_TIMEOUT_EN.
module wb_dma_copy #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic [AW-1:0]     src_addr_i,
    input  logic [AW-1:0]     dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [AW-1:0]     wb_adr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic              wb_stall_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     src_q, dst_q;
    logic [LEN_W-1:0]  rem_q;
    logic [DW-1:0]     dat_q;
    logic              err_q;
    logic              to_hit;
    logic              in_wait;

    assign in_wait = (state == RD_WAIT) || (state == WR_WAIT);

`ifdef WB_DMA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] to_cnt;

    // Counter restarts on every state change so each wait phase gets a full budget.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state_nxt != state)
            to_cnt <= '0;
        else if (in_wait)
            to_cnt <= to_cnt + CW'(1);
    end

    assign to_hit = in_wait && (to_cnt == CW'(TIMEOUT - 1));
`else
    // Watchdog not built: never fires.
    assign to_hit = in_wait && (TIMEOUT < 0);
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = (len_i != '0) ? RD_REQ : FIN;
            RD_REQ:  if (!wb_stall_i) state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (wb_err_i)      state_nxt = FIN;
                else if (wb_ack_i) state_nxt = WR_REQ;
                else if (to_hit)   state_nxt = FIN;
            end
            WR_REQ:  if (!wb_stall_i) state_nxt = WR_WAIT;
            WR_WAIT: begin
                if (wb_err_i)      state_nxt = FIN;
                else if (wb_ack_i) state_nxt = (rem_q == LEN_W'(1)) ? FIN : RD_REQ;
                else if (to_hit)   state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: address/count registers, read-holding register, sticky error.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            src_q <= '0;
            dst_q <= '0;
            rem_q <= '0;
            dat_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == IDLE && start_i) begin
                err_q <= 1'b0;
                if (len_i != '0) begin
                    src_q <= src_addr_i & ~AW'(3);
                    dst_q <= dst_addr_i & ~AW'(3);
                    rem_q <= len_i;
                end
            end
            if (in_wait) begin
                if (wb_err_i || (!wb_ack_i && to_hit)) begin
                    err_q <= 1'b1;
                end else if (wb_ack_i) begin
                    if (state == RD_WAIT) begin
                        dat_q <= wb_dat_i;
                    end else begin
                        src_q <= src_q + AW'(4);
                        dst_q <= dst_q + AW'(4);
                        rem_q <= rem_q - LEN_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        wb_we_o  = 1'b0;
        wb_adr_o = '0;
        case (state)
            RD_REQ:  begin wb_cyc_o = 1'b1; wb_stb_o = 1'b1; wb_adr_o = src_q; end
            RD_WAIT: begin wb_cyc_o = 1'b1; wb_adr_o = src_q; end
            WR_REQ:  begin wb_cyc_o = 1'b1; wb_stb_o = 1'b1; wb_we_o = 1'b1; wb_adr_o = dst_q; end
            WR_WAIT: begin wb_cyc_o = 1'b1; wb_we_o = 1'b1; wb_adr_o = dst_q; end
            default: ;
        endcase
    end

    assign busy_o   = (state != IDLE);
    assign done_o   = (state == FIN);
    assign err_o    = err_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = '1;

endmodule

// File: tb/tb_wb_dma_copy.sv
// Bench for wb_dma_copy: transaction-level model of the copy plus a randomized
// Wishbone slave; outputs compared every cycle on the falling edge.
module tb_wb_dma_copy;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] src_a = '0, dst_a = '0;
    logic [15:0] len = '0;
    logic        busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] dat_i = '0;
    logic        stall = 1'b0, ack = 1'b0, err = 1'b0;

    always #5 clk = ~clk;

    wb_dma_copy #(.AW(32), .DW(32), .LEN_W(16), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
        .src_addr_i(src_a), .dst_addr_i(dst_a), .len_i(len),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_dat_i(dat_i), .wb_stall_i(stall), .wb_ack_i(ack), .wb_err_i(err)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Slave knobs
    int stall_pct = 0, max_dly = 0, inj_idx = -1, force_stall = 0;
    bit noise = 0, hang = 0;

    // Transaction-level model
    typedef struct packed { logic we; logic [31:0] adr; } txn_t;
    txn_t        q[$];
    txn_t        cur;
    bit          m_active = 0, m_done = 0, m_pend = 0, m_err = 0;
    int          m_dly = 0, txn_no = 0, n_rd = 0, n_wr = 0, words_done = 0;
    logic [31:0] last_rd = '0;
    logic [31:0] rd_adr[$];
    logic [31:0] wmem[logic [31:0]];

    always @(negedge clk) begin : model
        bit   exp_cyc, exp_stb, nx_done, nx_active;
        txn_t t;
        if (rst) begin
            m_active = 0; m_done = 0; m_pend = 0; m_err = 0;
            q.delete();
            ack = 0; err = 0; stall = 0;
        end else begin
            exp_cyc = m_active && !m_done;
            exp_stb = exp_cyc && !m_pend;
            chk("busy", {31'b0, busy_o}, {31'b0, m_active});
            chk("done", {31'b0, done_o}, {31'b0, m_done});
            chk("cyc",  {31'b0, wb_cyc_o}, {31'b0, exp_cyc});
            chk("stb",  {31'b0, wb_stb_o}, {31'b0, exp_stb});
            chk("err",  {31'b0, err_o}, {31'b0, m_err});
            chk("sel",  {28'b0, wb_sel_o}, 32'hF);
            if (exp_stb && q.size() > 0) begin
                chk("adr", wb_adr_o, q[0].adr);
                chk("we", {31'b0, wb_we_o}, {31'b0, q[0].we});
                if (q[0].we) chk("wdat", wb_dat_o, last_rd);
            end
            ack = 0; err = 0; stall = 0; dat_i = $urandom;
            nx_done = 0;
            nx_active = m_active && !m_done;
            if (m_pend) begin
                if (m_dly > 0) m_dly--;
                else begin
                    m_pend = 0;
                    if (txn_no == inj_idx || hang) begin
                        if (!hang) begin err = 1; ack = 1'($urandom_range(0, 1)); end
                        m_err = 1; nx_done = 1;
                    end else begin
                        ack = 1;
                        if (!cur.we) begin dat_i = rd_fn(cur.adr); last_rd = dat_i; end
                        else begin words_done++; if (q.size() == 0) nx_done = 1; end
                    end
                    txn_no++;
                end
            end else if (exp_stb && q.size() > 0) begin
                if (force_stall > 0) begin stall = 1; force_stall--; end
                else stall = ($urandom_range(0, 99) < stall_pct);
                if (noise) begin ack = ($urandom_range(0, 3) == 0); err = ($urandom_range(0, 7) == 0); end
                if (!stall) begin
                    cur = q.pop_front();
                    m_pend = 1;
                    m_dly = hang ? TIMEOUT - 1 : $urandom_range(0, max_dly);
                    if (cur.we) begin n_wr++; wmem[cur.adr] = wb_dat_o; end
                    else begin n_rd++; rd_adr.push_back(cur.adr); end
                end
            end else if (noise) begin
                ack = ($urandom_range(0, 3) == 0); err = ($urandom_range(0, 7) == 0);
            end
            if (!m_active && start) begin
                nx_active = 1; m_err = 0; txn_no = 0; words_done = 0; n_rd = 0; n_wr = 0;
                rd_adr.delete(); q.delete();
                for (int i = 0; i < int'(len); i++) begin
                    t.we = 0; t.adr = (src_a & ~32'd3) + 32'(4 * i); q.push_back(t);
                    t.we = 1; t.adr = (dst_a & ~32'd3) + 32'(4 * i); q.push_back(t);
                end
                if (len == 0) nx_done = 1;
            end
            m_active = nx_active;
            m_done = nx_done;
        end
    end

    // Launch one copy; lat = cycles from the start-sampling edge to done.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                       input bit poke, output int lat);
        wmem.delete();
        @(posedge clk); #1;
        src_a = s; dst_a = d; len = l; start = 1;
        @(posedge clk); #1;
        start = 0; lat = 1;
        while (!done_o && lat < 4000) begin
            @(posedge clk); #1;
            lat++;
            start = poke && (lat == 2);
            if (start) len = 16'($urandom_range(0, 9));
        end
        start = 0;
        chk("done_seen", {31'b0, done_o}, 32'd1);
    endtask

    task automatic chk_mem(input logic [31:0] s, input logic [31:0] d, input int words);
        for (int i = 0; i < words; i++) begin
            logic [31:0] a;
            a = d + 32'(4 * i);
            chk("mem", wmem.exists(a) ? wmem[a] : 32'hXXXX_XXXX, rd_fn(s + 32'(4 * i)));
        end
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, l, words;
        logic [31:0] s, d;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy_o}, 0);
        chk("rst_done", {31'b0, done_o}, 0);
        chk("rst_err",  {31'b0, err_o}, 0);
        chk("rst_cyc",  {31'b0, wb_cyc_o}, 0);
        chk("rst_stb",  {31'b0, wb_stb_o}, 0);
        chk("rst_we",   {31'b0, wb_we_o}, 0);
        chk("rst_adr",  wb_adr_o, 0);
        chk("rst_dat",  wb_dat_o, 0);
        chk("rst_sel",  {28'b0, wb_sel_o}, 32'hF);
        rst = 0;

        // Zero-stall, next-cycle ack: 3 words -> done 13 cycles after start
        run(32'h1_0000, 32'h1_0100, 3, 0, lat);
        chk("lat_len3", lat, 13);
        chk("err_len3", {31'b0, err_o}, 0);
        chk("rd_len3", n_rd, 3);
        chk("wr_len3", n_wr, 3);
        chk_mem(32'h1_0000, 32'h1_0100, 3);

        // len=0: straight to FIN, no bus traffic
        run(32'h1_0000, 32'h1_0100, 0, 0, lat);
        chk("lat_len0", lat, 1);
        chk("bus_len0", n_rd + n_wr, 0);

        // 5-cycle stall on the read request
        force_stall = 5;
        run(32'h1_0040, 32'h1_0200, 1, 0, lat);
        chk("lat_stall", lat, 10);
        chk("rd_stall", n_rd, 1);
        chk_mem(32'h1_0040, 32'h1_0200, 1);

        // Bus error on 2nd write of a 4-word copy
        inj_idx = 3;
        run(32'h1_0000, 32'h1_0300, 4, 0, lat);
        chk("lat_err", lat, 9);
        chk("err_set", {31'b0, err_o}, 1);
        chk("wr_err", n_wr, 2);
        chk_mem(32'h1_0000, 32'h1_0300, 1);
        inj_idx = -1;
        run(32'h1_0000, 32'h1_0300, 1, 0, lat);
        chk("err_clr", {31'b0, err_o}, 0);

        // Source address wraps past the top of the space
        run(32'hFFFF_FFFC, 32'h3000_0000, 2, 0, lat);
        chk("wrap_adr", rd_adr.size() > 1 ? rd_adr[1] : 32'hDEAD_BEEF, 32'h0);
        chk_mem(32'hFFFF_FFFC, 32'h3000_0000, 2);

        // Reset while waiting for a write ack
        max_dly = 3;
        @(posedge clk); #1;
        src_a = 32'h1_0000; dst_a = 32'h1_0400; len = 4; start = 1;
        @(posedge clk); #1;
        start = 0; lat = 0;
        while (!(wb_cyc_o && wb_we_o && !wb_stb_o) && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("wr_wait_seen", {31'b0, wb_cyc_o && wb_we_o && !wb_stb_o}, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("rst_mid_cyc",  {31'b0, wb_cyc_o}, 0);
        chk("rst_mid_stb",  {31'b0, wb_stb_o}, 0);
        chk("rst_mid_busy", {31'b0, busy_o}, 0);
        chk("rst_mid_done", {31'b0, done_o}, 0);
        repeat (2) @(posedge clk);

        // Randomized copies: stalls, ack delays, spurious ack/err, errors, ignored restarts
        noise = 1;
        for (int k = 0; k < 30; k++) begin
            l = $urandom_range(0, 6);
            s = 32'h1000_0000 + (32'($urandom_range(0, 255)) << 2);
            d = 32'h2000_0000 + (32'($urandom_range(0, 255)) << 2);
            stall_pct = $urandom_range(0, 60);
            max_dly = $urandom_range(0, 3);
            inj_idx = (l > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * l - 1) : -1;
            run(s, d, 16'(l), 1'($urandom_range(0, 1)), lat);
            words = (inj_idx < 0) ? l : inj_idx / 2;
            chk("rnd_err", {31'b0, err_o}, {31'b0, inj_idx >= 0});
            chk("rnd_wr", n_wr, (inj_idx < 0) ? l : (inj_idx + 1) / 2);
            chk_mem(s, d, words);
            @(posedge clk);
        end
        noise = 0; inj_idx = -1; stall_pct = 0; max_dly = 0;

`ifdef WB_DMA_TIMEOUT_EN
        // Slave that never answers: watchdog ends the copy with an error
        hang = 1;
        run(32'h1_0000, 32'h1_0500, 1, 0, lat);
        hang = 0;
        chk("lat_timeout", lat, TIMEOUT + 2);
        chk("err_timeout", {31'b0, err_o}, 1);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
